// File: rtl/sequential_signed_divider_pkg.sv
// Shared definitions for the sequential signed divider.
// Optional feature macro: SEQ_DIV_ZERO_DETECT_EN (early exit on a zero divisor).
package sequential_signed_divider_pkg;

  localparam int NUMBITS_DEF = 16;

  typedef logic [2:0] state_t;

  // Controller state encoding; any other code falls back to Idle.
  localparam state_t ST_IDLE  = 3'b000;
  localparam state_t ST_INPUT = 3'b001;
  localparam state_t ST_CALC  = 3'b010;
  localparam state_t ST_CORR  = 3'b011;
  localparam state_t ST_READY = 3'b100;

endpackage

// File: rtl/sequential_signed_divider_if.sv
// Handshake and data bus of the sequential signed divider.
// Optional feature macro: SEQ_DIV_ZERO_DETECT_EN adds the div_by_zero flag.
interface sequential_signed_divider_if #(parameter int NUMBITS = 16);

  logic               start;
  logic [NUMBITS-1:0] dividend;
  logic [NUMBITS-1:0] divisor;
  logic [NUMBITS-1:0] quotient;
  logic [NUMBITS-1:0] remainder;
  logic               ready;
`ifdef SEQ_DIV_ZERO_DETECT_EN
  logic               div_by_zero;

  modport master (output start, dividend, divisor,
                  input  quotient, remainder, ready, div_by_zero);
  modport slave  (input  start, dividend, divisor,
                  output quotient, remainder, ready, div_by_zero);
`else
  modport master (output start, dividend, divisor,
                  input  quotient, remainder, ready);
  modport slave  (input  start, dividend, divisor,
                  output quotient, remainder, ready);
`endif

endinterface

// File: rtl/sequential_signed_divider_controller.sv
// Sequencing FSM of the divider; drives the datapath enables.
// Optional feature macro: SEQ_DIV_ZERO_DETECT_EN (InputData -> Ready on zero divisor).
//
// state     | meaning
// ----------+-------------------------------------------------
// ST_IDLE   | waiting for start; operands captured on accept
// ST_INPUT  | clear partial remainder and iteration counter
// ST_CALC   | one restoring step per cycle, NUMBITS cycles
// ST_CORR   | apply result signs
// ST_READY  | results valid, ready pulse
module divider_controller
  import sequential_signed_divider_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  input  logic i_cnt_last,
`ifdef SEQ_DIV_ZERO_DETECT_EN
  input  logic i_zero,
`endif
  output logic o_accept,
  output logic o_load,
  output logic o_calc,
  output logic o_correct,
  output logic o_ready
);

  state_t r_state;
  state_t w_next;

  // State register, aborts any division on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = ST_IDLE;
    case (r_state)
      ST_IDLE:  w_next = i_start ? ST_INPUT : ST_IDLE;
`ifdef SEQ_DIV_ZERO_DETECT_EN
      ST_INPUT: w_next = i_zero ? ST_READY : ST_CALC;
`else
      ST_INPUT: w_next = ST_CALC;
`endif
      ST_CALC:  w_next = i_cnt_last ? ST_CORR : ST_CALC;
      ST_CORR:  w_next = ST_READY;
      ST_READY: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  assign o_accept  = (r_state == ST_IDLE) && i_start;
  assign o_load    = (r_state == ST_INPUT);
  assign o_calc    = (r_state == ST_CALC);
  assign o_correct = (r_state == ST_CORR);
  assign o_ready   = (r_state == ST_READY);

endmodule

// File: rtl/sequential_signed_divider.sv
// Restoring sequential signed divider, truncating toward zero.
// Optional feature macro: SEQ_DIV_ZERO_DETECT_EN (div_by_zero flag, early finish).
module sequential_signed_divider
  import sequential_signed_divider_pkg::*;
#(
  parameter int NUMBITS = NUMBITS_DEF
) (
  input logic clk,
  input logic reset,
  sequential_signed_divider_if.slave bus
);

  localparam int CW = (NUMBITS > 2) ? $clog2(NUMBITS) : 1;

  // r_dvd starts as the dividend magnitude and fills with quotient bits.
  logic [NUMBITS-1:0] r_dvd;
  logic [NUMBITS-1:0] r_dvsr;
  logic [NUMBITS-1:0] r_rem;
  logic               r_sign_dvd;
  logic               r_sign_q;
  logic [CW-1:0]      r_cnt;
  logic [NUMBITS-1:0] r_quot;
  logic [NUMBITS-1:0] r_remd;

  logic               w_accept, w_load, w_calc, w_correct, w_ready;
  logic               w_cnt_last;
  logic               w_zero;
  logic [NUMBITS:0]   w_shift;
  logic               w_ge;
  logic [NUMBITS-1:0] w_sub;
  logic [NUMBITS-1:0] w_rem_next;
  logic [NUMBITS-1:0] w_dvd_mag;
  logic [NUMBITS-1:0] w_dvsr_mag;

  // Magnitudes are unsigned, so |most-negative| is exact.
  assign w_dvd_mag  = bus.dividend[NUMBITS-1] ? -bus.dividend : bus.dividend;
  assign w_dvsr_mag = bus.divisor[NUMBITS-1]  ? -bus.divisor  : bus.divisor;

  assign w_zero     = (r_dvsr == '0);
  assign w_cnt_last = (r_cnt == CW'(NUMBITS - 1));
  assign w_shift    = {r_rem, r_dvd[NUMBITS-1]};
  assign w_ge       = (w_shift >= {1'b0, r_dvsr});
  assign w_sub      = w_shift[NUMBITS-1:0] - r_dvsr;
  assign w_rem_next = w_ge ? w_sub : w_shift[NUMBITS-1:0];

  divider_controller u_ctrl (
    .clk        (clk),
    .reset      (reset),
    .i_start    (bus.start),
    .i_cnt_last (w_cnt_last),
`ifdef SEQ_DIV_ZERO_DETECT_EN
    .i_zero     (w_zero),
`endif
    .o_accept   (w_accept),
    .o_load     (w_load),
    .o_calc     (w_calc),
    .o_correct  (w_correct),
    .o_ready    (w_ready)
  );

  // Working registers: capture on the start cycle, then iterate.
  // Operands are taken on accept so later bus changes cannot leak in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dvd      <= '0;
      r_dvsr     <= '0;
      r_rem      <= '0;
      r_sign_dvd <= 1'b0;
      r_sign_q   <= 1'b0;
      r_cnt      <= '0;
    end else if (w_accept) begin
      r_dvd      <= w_dvd_mag;
      r_dvsr     <= w_dvsr_mag;
      r_sign_dvd <= bus.dividend[NUMBITS-1];
      r_sign_q   <= bus.dividend[NUMBITS-1] ^ bus.divisor[NUMBITS-1];
    end else if (w_load) begin
      r_rem <= '0;
      r_cnt <= '0;
    end else if (w_calc) begin
      r_rem <= w_rem_next;
      r_dvd <= {r_dvd[NUMBITS-2:0], w_ge};
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Result registers hold from Ready until the next operation writes them.
  // A zero divisor forces all-ones so the sign fix cannot turn it into 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_quot <= '0;
      r_remd <= '0;
`ifdef SEQ_DIV_ZERO_DETECT_EN
    end else if (w_load && w_zero) begin
      r_quot <= '1;
      r_remd <= r_sign_dvd ? -r_dvd : r_dvd;
`endif
    end else if (w_correct) begin
      r_quot <= w_zero ? '1 : (r_sign_q ? -r_dvd : r_dvd);
      r_remd <= r_sign_dvd ? -r_rem : r_rem;
    end
  end

`ifdef SEQ_DIV_ZERO_DETECT_EN
  logic r_dbz;

  // Remember whether the current operation took the zero-divisor exit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_dbz <= 1'b0;
    else if (w_load) r_dbz <= w_zero;
  end

  assign bus.div_by_zero = w_ready & r_dbz;
`endif

  assign bus.quotient  = r_quot;
  assign bus.remainder = r_remd;
  assign bus.ready     = w_ready;

endmodule

// File: tb/tb_sequential_signed_divider.sv
// Self-checking bench for sequential_signed_divider (NUMBITS = 16).
// Build with SEQ_DIV_ZERO_DETECT_EN to exercise the early zero-divisor exit.
module tb_sequential_signed_divider;

  localparam int W = 16;
`ifdef SEQ_DIV_ZERO_DETECT_EN
  localparam bit ZD = 1'b1;
`else
  localparam bit ZD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;

  sequential_signed_divider_if #(.NUMBITS(W)) bus ();

  sequential_signed_divider #(.NUMBITS(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed integer division, which truncates toward zero.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
    int sa, sb, tq, tr;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sb == 0) begin
      q = '1;
      r = a;
    end else begin
      tq = sa / sb;
      tr = sa % sb;
      q  = tq[W-1:0];
      r  = tr[W-1:0];
    end
  endfunction

  // One division; start re-asserted in cycle ign_cyc (0 = never) and
  // operands scrambled after cycle 0. Returns with cycle lat+1 in progress.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input int ign_cyc);
    logic [W-1:0] eq, er;
    int lat, seen, nrdy;
    ref_div(a, b, eq, er);
    lat  = (ZD && (b == '0)) ? 2 : W + 3;
    seen = -1;
    nrdy = 0;
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    for (int k = 1; k <= lat + 1; k++) begin
      @(posedge clk);
      @(negedge clk);
      bus.start    = (k == ign_cyc);
      bus.dividend = W'($urandom);
      bus.divisor  = W'($urandom);
      if (bus.ready === 1'b1) begin
        nrdy++;
        if (seen < 0) seen = k;
        check("quotient", 32'(bus.quotient), 32'(eq));
        check("remainder", 32'(bus.remainder), 32'(er));
`ifdef SEQ_DIV_ZERO_DETECT_EN
        check("div_by_zero", 32'(bus.div_by_zero), 32'(b == '0));
`endif
      end
    end
    check("ready_cycle", 32'(seen), 32'(lat));
    check("ready_count", 32'(nrdy), 32'd1);
    check("hold_quotient", 32'(bus.quotient), 32'(eq));
    check("hold_remainder", 32'(bus.remainder), 32'(er));
    bus.start = 1'b0;
  endtask

  initial begin
    int nrdy;
    logic [W-1:0] ra, rb;

    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    #12;
    check("rst_quotient", 32'(bus.quotient), 32'd0);
    check("rst_remainder", 32'(bus.remainder), 32'd0);
    check("rst_ready", 32'(bus.ready), 32'd0);
`ifdef SEQ_DIV_ZERO_DETECT_EN
    check("rst_div_by_zero", 32'(bus.div_by_zero), 32'd0);
`endif
    @(negedge clk);
    reset = 1'b1;

    // Second start in cycle 5 is ignored; next start lands in cycle 20.
    run_div(16'd100, 16'd7, 5);
    run_div(-16'sd100, 16'd7, 0);
    run_div(16'd100, -16'sd7, 0);
    run_div(16'h8000, 16'hFFFF, 0);
    run_div(16'd1234, 16'd0, 0);
    run_div(-16'sd1234, 16'd0, 0);
    run_div(16'd7, 16'd100, 0);
    run_div(16'h8000, 16'h8000, 0);
    run_div(16'h7FFF, 16'h8000, 0);

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = W'($urandom_range(1, 9));
        2: ra = 16'h8000;
        default: ;
      endcase
      run_div(ra, rb, 0);
    end

    run_div(-16'sd100, -16'sd7, 0);

    // Reset in cycle 8 aborts the division without any ready pulse.
    nrdy = 0;
    bus.start    = 1'b1;
    bus.dividend = 16'd100;
    bus.divisor  = 16'd7;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.ready === 1'b1) nrdy++;
    end
    reset = 1'b0;
    #1;
    check("abort_quotient", 32'(bus.quotient), 32'd0);
    check("abort_remainder", 32'(bus.remainder), 32'd0);
    check("abort_ready", 32'(bus.ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.ready === 1'b1) nrdy++;
    end
    reset = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (bus.ready === 1'b1) nrdy++;
    end
    check("abort_no_ready", 32'(nrdy), 32'd0);
    check("abort_hold_quotient", 32'(bus.quotient), 32'd0);

    run_div(16'd50, 16'd5, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
